// File: rtl/comma_align_ctrl.sv
// 1000BASE-X receive word aligner: finds the comma bit offset in a 20-bit sliding
// window, confirms it over several commas, then holds the barrel-shift offset.
module comma_align_ctrl #(
  parameter int LOCK_COMMAS  = 3,
  parameter int VERIFY_WORDS = 64,
  parameter int LOSS_WORDS   = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] raw_code,
  input  logic       raw_valid,
  input  logic       code_synch_status,
  output logic [9:0] aligned_code,
  output logic       aligned_valid,
  output logic [3:0] align_offset,
  output logic       locked,
  output logic [7:0] realign_count
);

  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COMMAS);
  localparam logic [7:0] VERIFY_CNT = 8'(VERIFY_WORDS);
  localparam logic [7:0] LOSS_CNT   = 8'(LOSS_WORDS);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_prev;
  logic [3:0]  r_cand;
  logic [3:0]  r_ccnt;
  logic [7:0]  r_wcnt;
  logic [7:0]  r_lcnt;
  logic [3:0]  r_offset;
  logic [7:0]  r_realign;
  logic [9:0]  r_aligned_code;
  logic        r_aligned_valid;

  logic [3:0]  w_cand_nxt;
  logic [3:0]  w_ccnt_nxt;
  logic [7:0]  w_wcnt_nxt;
  logic [7:0]  w_lcnt_nxt;
  logic [3:0]  w_offset_nxt;
  logic [7:0]  w_realign_nxt;
  logic [3:0]  w_ccnt_inc;
  logic [7:0]  w_wcnt_inc;
  logic [7:0]  w_lcnt_inc;

  logic [19:0] w_win;
  logic [15:0] w_comma;
  logic [3:0]  w_first;
  logic        w_any;
  logic        w_cand_hit;

  // Candidate k is window bits [19-k -: 10]; the comma test only needs its top seven bits.
  function automatic logic f_comma_at(input logic [19:0] win, input logic [3:0] k);
    logic [6:0] hi;
    hi = 7'(win >> (5'd13 - {1'b0, k}));
    return (hi == 7'b0011111) || (hi == 7'b1100000);
  endfunction

  function automatic logic [9:0] f_slice(input logic [19:0] win, input logic [3:0] k);
    return 10'(win >> (5'd10 - {1'b0, k}));
  endfunction

  assign w_win      = {r_prev, raw_code};
  assign w_any      = |w_comma;
  assign w_cand_hit = w_comma[r_cand];
  assign w_ccnt_inc = r_ccnt + 4'd1;
  assign w_wcnt_inc = r_wcnt + 8'd1;
  assign w_lcnt_inc = r_lcnt + 8'd1;

  // Comma detection at every offset; the lowest offset with a comma is reported.
  always_comb begin
    w_comma = 16'd0;
    w_first = 4'd0;
    for (int k = 0; k < 10; k++) begin
      w_comma[k] = f_comma_at(w_win, 4'(k));
    end
    for (int k = 9; k >= 0; k--) begin
      w_first = w_comma[k] ? 4'(k) : w_first;
    end
  end

  // Next-state and counter decisions for one valid word.
  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_ccnt_nxt    = r_ccnt;
    w_wcnt_nxt    = r_wcnt;
    w_lcnt_nxt    = r_lcnt;
    w_offset_nxt  = r_offset;
    w_realign_nxt = r_realign;
    case (r_state)
      ST_SEARCH: begin
        if (w_any) begin
          w_cand_nxt  = w_first;
          w_ccnt_nxt  = 4'd1;
          w_wcnt_nxt  = 8'd0;
          w_state_nxt = ST_VERIFY;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_VERIFY: begin
        // A comma at the current candidate outranks commas elsewhere in the window.
        if (w_cand_hit) begin
          w_ccnt_nxt = w_ccnt_inc;
          w_wcnt_nxt = 8'd0;
          if (w_ccnt_inc == LOCK_CNT) begin
            w_offset_nxt = r_cand;
            w_state_nxt  = ST_LOCKED;
          end else begin
            w_state_nxt = ST_VERIFY;
          end
        end else if (w_any) begin
          w_cand_nxt = w_first;
          w_ccnt_nxt = 4'd1;
          w_wcnt_nxt = 8'd0;
        end else if (w_wcnt_inc == VERIFY_CNT) begin
          w_wcnt_nxt  = 8'd0;
          w_state_nxt = ST_SEARCH;
        end else begin
          w_wcnt_nxt = w_wcnt_inc;
        end
      end
      ST_LOCKED: begin
        if (code_synch_status) begin
          w_lcnt_nxt = 8'd0;
        end else if (w_lcnt_inc == LOSS_CNT) begin
          w_lcnt_nxt    = 8'd0;
          w_state_nxt   = ST_SEARCH;
          w_realign_nxt = (r_realign == 8'hFF) ? r_realign : (r_realign + 8'd1);
        end else begin
          w_lcnt_nxt = w_lcnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

  // Controller state register; gap cycles leave everything untouched.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_SEARCH;
      r_cand    <= 4'd0;
      r_ccnt    <= 4'd0;
      r_wcnt    <= 8'd0;
      r_lcnt    <= 8'd0;
      r_offset  <= 4'd0;
      r_realign <= 8'd0;
    end else if (raw_valid) begin
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_ccnt    <= w_ccnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_lcnt    <= w_lcnt_nxt;
      r_offset  <= w_offset_nxt;
      r_realign <= w_realign_nxt;
    end
  end

  // Datapath: previous-word register and barrel shift using the pre-update offset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_prev          <= 10'd0;
      r_aligned_code  <= 10'd0;
      r_aligned_valid <= 1'b0;
    end else if (raw_valid) begin
      r_prev          <= raw_code;
      r_aligned_code  <= f_slice(w_win, r_offset);
      r_aligned_valid <= 1'b1;
    end else begin
      r_aligned_valid <= 1'b0;
    end
  end

  // Output decode from the state register.
  always_comb begin
    case (r_state)
      ST_LOCKED: locked = 1'b1;
      default:   locked = 1'b0;
    endcase
  end

  assign aligned_code  = r_aligned_code;
  assign aligned_valid = r_aligned_valid;
  assign align_offset  = r_offset;
  assign realign_count = r_realign;

endmodule

// File: tb/tb_comma_align_ctrl.sv
// Self-checking bench for comma_align_ctrl: vector table for the basic lock cases,
// hand-written sequences for VERIFY timeout, loss of sync, saturation and reset.
module tb_comma_align_ctrl;

  localparam logic [9:0] K_NEG  = 10'b0011111010;
  localparam logic [9:0] K_POS  = 10'b1100000101;
  localparam logic [9:0] D_FILL = 10'b1010101010;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] raw_code;
  logic       raw_valid;
  logic       code_synch_status;
  logic [9:0] aligned_code;
  logic       aligned_valid;
  logic [3:0] align_offset;
  logic       locked;
  logic [7:0] realign_count;

  comma_align_ctrl #(
    .LOCK_COMMAS  (3),
    .VERIFY_WORDS (64),
    .LOSS_WORDS   (16)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .raw_code          (raw_code),
    .raw_valid         (raw_valid),
    .code_synch_status (code_synch_status),
    .aligned_code      (aligned_code),
    .aligned_valid     (aligned_valid),
    .align_offset      (align_offset),
    .locked            (locked),
    .realign_count     (realign_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst_before;
    logic [9:0] code;
    logic       valid;
    logic       status;
    logic       e_lk;
    logic [3:0] e_off;
    logic [7:0] e_rc;
    logic       chk_code;
    logic [9:0] e_code;
  } vec_t;

  vec_t       vecs [12];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] sb_q [$];
  logic [9:0] m_prev = 10'd0;
  logic [9:0] m_last = 10'd0;
  logic [3:0] m_off  = 4'd0;
  logic       x_lk   = 1'b0;
  logic [3:0] x_off  = 4'd0;
  logic [7:0] x_rc   = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Candidate k of a 20-bit window is the 10 bits starting k bits after the first received bit.
  function automatic logic [9:0] ref_slice(input logic [19:0] w, input logic [3:0] k);
    logic [19:0] t;
    t = w << k;
    return t[19:10];
  endfunction

  // Two words of filler with one K28.5 (RD-) starting s bits into the first word.
  function automatic logic [19:0] make_pair(input int s);
    logic [19:0] p;
    p = 20'hAAAAA;
    p[19-s -: 10] = K_NEG;
    return p;
  endfunction

  task automatic step(input logic [9:0] code, input logic v, input logic st,
                      input logic e_lk, input logic [3:0] e_off, input logic [7:0] e_rc);
    logic [9:0] exp_code;
    raw_code          = code;
    raw_valid         = v;
    code_synch_status = st;
    if (v) begin
      sb_q.push_back(ref_slice({m_prev, code}, m_off));
      m_prev = code;
    end
    @(posedge Clk);
    #1;
    chk("aligned_valid", 32'(aligned_valid), 32'(v));
    if (aligned_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got unexpected word 0x%0h expected none", aligned_code);
      end else begin
        exp_code = sb_q.pop_front();
        chk("aligned_code", 32'(aligned_code), 32'(exp_code));
        m_last = exp_code;
      end
    end else begin
      chk("aligned_code_hold", 32'(aligned_code), 32'(m_last));
    end
    chk("locked", 32'(locked), 32'(e_lk));
    chk("align_offset", 32'(align_offset), 32'(e_off));
    chk("realign_count", 32'(realign_count), 32'(e_rc));
    m_off = e_off;
  endtask

  task automatic wx(input logic [9:0] code, input logic v, input logic st);
    step(code, v, st, x_lk, x_off, x_rc);
  endtask

  task automatic rgap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      wx(10'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic pair(input int s, input logic st, input logic lk_after,
                      input logic [3:0] off_after, input logic gaps);
    logic [19:0] p;
    p = make_pair(s);
    wx(p[19:10], 1'b1, st);
    if (gaps) rgap();
    x_lk  = lk_after;
    x_off = off_after;
    wx(p[9:0], 1'b1, st);
    if (gaps) rgap();
  endtask

  task automatic lose(input logic [7:0] rc_after);
    for (int i = 0; i < 15; i++) wx(D_FILL, 1'b1, 1'b0);
    x_lk = 1'b0;
    x_rc = rc_after;
    wx(D_FILL, 1'b1, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_code"}, 32'(aligned_code), 32'd0);
    chk({tag, "_valid"}, 32'(aligned_valid), 32'd0);
    chk({tag, "_offset"}, 32'(align_offset), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_realign"}, 32'(realign_count), 32'd0);
  endtask

  // Asserted between clock edges so the clear must be asynchronous.
  task automatic do_reset();
    #3;
    Reset = 1'b1;
    #1;
    check_zero("async_reset");
    m_prev = 10'd0;
    m_last = 10'd0;
    m_off  = 4'd0;
    sb_q.delete();
    x_lk   = 1'b0;
    x_off  = 4'd0;
    x_rc   = 8'd0;
    for (int i = 0; i < 2; i++) begin
      raw_valid         = 1'($urandom_range(0, 1));
      raw_code          = 10'($urandom);
      code_synch_status = 1'($urandom_range(0, 1));
      @(posedge Clk);
      #1;
      check_zero("in_reset");
    end
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset             = 1'b0;
    raw_code          = 10'd0;
    raw_valid         = 1'b0;
    code_synch_status = 1'b1;

    // Aligned K28.5 stream: offset 0 selects the previous word.
    vecs[0]  = '{1'b0, K_NEG,         1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0};
    vecs[1]  = '{1'b0, K_POS,         1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0};
    vecs[2]  = '{1'b0, 10'h3FF,       1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0};
    vecs[3]  = '{1'b0, K_NEG,         1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0};
    vecs[4]  = '{1'b0, K_POS,         1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b1, K_NEG};
    vecs[5]  = '{1'b0, K_NEG,         1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b1, K_POS};
    // Same stream delayed by three bits.
    vecs[6]  = '{1'b1, 10'b0000011111, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0};
    vecs[7]  = '{1'b0, 10'b0101100000, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0};
    vecs[8]  = '{1'b0, 10'b1010011111, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 10'd0};
    vecs[9]  = '{1'b0, 10'b0101100000, 1'b1, 1'b1, 1'b1, 4'd3, 8'd0, 1'b0, 10'd0};
    vecs[10] = '{1'b0, 10'b1010011111, 1'b1, 1'b1, 1'b1, 4'd3, 8'd0, 1'b1, K_POS};
    vecs[11] = '{1'b0, 10'b0101100000, 1'b1, 1'b1, 1'b1, 4'd3, 8'd0, 1'b1, K_NEG};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst_before) do_reset();
      step(vecs[i].code, vecs[i].valid, vecs[i].status,
           vecs[i].e_lk, vecs[i].e_off, vecs[i].e_rc);
      x_lk  = vecs[i].e_lk;
      x_off = vecs[i].e_off;
      x_rc  = vecs[i].e_rc;
      if (vecs[i].chk_code) chk("lock_word_code", 32'(aligned_code), 32'(vecs[i].e_code));
    end

    // Two commas at offset 5 then a switch to offset 2: the count restarts at one.
    do_reset();
    wx(D_FILL, 1'b1, 1'b1);
    pair(5, 1'b1, 1'b0, 4'd0, 1'b0);
    pair(5, 1'b1, 1'b0, 4'd0, 1'b0);
    pair(2, 1'b1, 1'b0, 4'd0, 1'b0);
    pair(2, 1'b1, 1'b0, 4'd0, 1'b0);
    pair(2, 1'b1, 1'b1, 4'd2, 1'b0);
    wx(D_FILL, 1'b1, 1'b1);

    // 63 comma-less words keep VERIFY alive.
    do_reset();
    wx(D_FILL, 1'b1, 1'b1);
    pair(5, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 62; i++) wx(D_FILL, 1'b1, 1'b1);
    pair(5, 1'b1, 1'b0, 4'd0, 1'b0);
    pair(5, 1'b1, 1'b1, 4'd5, 1'b0);

    // The 64th comma-less word drops back to SEARCH, so three fresh commas are needed.
    do_reset();
    wx(D_FILL, 1'b1, 1'b1);
    pair(5, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 63; i++) wx(D_FILL, 1'b1, 1'b1);
    pair(5, 1'b1, 1'b0, 4'd0, 1'b0);
    pair(5, 1'b1, 1'b0, 4'd0, 1'b0);
    pair(5, 1'b1, 1'b1, 4'd5, 1'b0);

    // Locked: foreign commas ignored, 15 bad words tolerated, gaps do not break the run.
    pair(2, 1'b1, 1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 15; i++) begin
      wx(D_FILL, 1'b1, 1'b0);
      if (i == 7) wx(D_FILL, 1'b0, 1'b0);
    end
    wx(D_FILL, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) wx(D_FILL, 1'b1, 1'b0);
    wx(10'h0F0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) wx(D_FILL, 1'b1, 1'b0);
    x_lk = 1'b0;
    x_rc = 8'd1;
    wx(D_FILL, 1'b1, 1'b0);
    wx(D_FILL, 1'b1, 1'b1);

    // Relock at a new offset, then drive realign_count into saturation.
    pair(2, 1'b1, 1'b0, 4'd5, 1'b0);
    pair(2, 1'b1, 1'b0, 4'd5, 1'b0);
    pair(2, 1'b1, 1'b1, 4'd2, 1'b0);
    lose(8'd2);
    for (int r = 3; r <= 256; r++) begin
      pair(5, 1'b1, 1'b0, x_off, 1'b0);
      pair(5, 1'b1, 1'b0, x_off, 1'b0);
      pair(5, 1'b1, 1'b1, 4'd5, 1'b0);
      lose((r > 255) ? 8'd255 : 8'(r));
    end

    // Reset in the middle of VERIFY with random gaps; earlier commas must not count.
    wx(D_FILL, 1'b1, 1'b1);
    pair(5, 1'b1, 1'b0, 4'd5, 1'b1);
    pair(5, 1'b1, 1'b0, 4'd5, 1'b1);
    do_reset();
    pair(5, 1'b1, 1'b0, 4'd0, 1'b1);
    pair(5, 1'b1, 1'b0, 4'd0, 1'b1);
    pair(5, 1'b1, 1'b1, 4'd5, 1'b1);
    wx(D_FILL, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
